pulse_scheduler: RTL and testbench
==================================

Name: pulse_scheduler

Overview:
- Timed issue queue that sits between the proc core's pulse-command path and the per-channel pulse parameter register.
- Buffers pulse commands, each with an absolute trigger time. Each command carries the command word and the proc register value it was written with.
- When the local timer reaches a command's trigger time, the block replays that command into the pulse register: write enable, command word, register value and cstrobe together in one cycle.
- The pulse register stores parameters and cstrobe in the same cycle, so they reach the generator aligned.

Parameters:
- CMD_WIDTH, 79, pulse command word width (env 24 + phase 17 + freq 9 + amp 16 + cfg 4 + 9 control bits).
- DATA_WIDTH, 32, width of the register value carried with each command.
- TIME_WIDTH, 32, timer and trigger-time width.
- DEPTH, 8, queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_in  in  CMD_WIDTH  pulse command word to enqueue
- reg_in  in  DATA_WIDTH  register value paired with cmd_in
- time_in  in  TIME_WIDTH  absolute trigger time of cmd_in
- cmd_valid  in  1  enqueue request
- cmd_ready  out  1  queue can accept (count < DEPTH)
- run  in  1  timer advance and issue enable
- time_clr  in  1  synchronous timer clear
- flush  in  1  synchronous queue flush
- err_clr  in  1  clears late_err
- pulse_cmd_out  out  CMD_WIDTH  command to pulse register
- reg_out  out  DATA_WIDTH  register value to pulse register
- pulse_write_en  out  1  one-cycle write strobe to pulse register
- cstrobe_out  out  1  one-cycle pulse start strobe, coincident with pulse_write_en
- time_cnt  out  TIME_WIDTH  current timer value
- fill_count  out  $clog2(DEPTH)+1  occupied entries
- late_err  out  1  sticky: a command issued after its trigger time

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registered outputs are 0, time_cnt is 0, fill_count is 0, late_err is 0;
  - queue pointers are 0;
  - cmd_ready is 1 once rst_n is high.
- Asserting rst_n mid-operation discards queued entries and any pending issue; no strobe is emitted in the reset cycle.
- Timer:
  - time_clr high: time_cnt = 0 next cycle, regardless of run.
  - Otherwise, when run is high, time_cnt increments by 1 each cycle and wraps modulo 2^TIME_WIDTH.
  - When run is low the timer holds.
- Enqueue: push occurs when cmd_valid && cmd_ready.
  - cmd_ready = (fill_count < DEPTH), combinational from registered count only.
  - A full queue never accepts a push, even when a pop happens in the same cycle.
  - A pushed entry becomes the head candidate no earlier than the cycle after the push.
- Issue decision, evaluated each cycle the queue is non-empty, run is high and flush is low:
  - diff = head.time − time_cnt, computed modulo 2^TIME_WIDTH and interpreted as signed.
  - diff == 0 → on-time issue.
  - diff < 0 (MSB set) → late issue; late_err is set in the same update.
  - diff > 0 → wait.
- Issue action:
  - pop the head;
  - next cycle, pulse_write_en = cstrobe_out = 1 for exactly one cycle, with pulse_cmd_out/reg_out = the popped entry.
  - Latency: time_cnt == T in cycle n → strobes high in cycle n+1.
  - At most one issue per cycle. Back-to-back entries with equal or consecutive times issue on consecutive cycles; later ones are late if their time has passed.
- pulse_cmd_out/reg_out hold the last issued values between strobes; the strobes are 0 otherwise.
- Simultaneous push and pop: both take effect and fill_count is unchanged.
- Flush:
  - empties the queue next cycle (fill_count = 0, pointers equal);
  - suppresses any issue decided in the same cycle;
  - has priority over a same-cycle push (the push is dropped, and cmd_ready is still sampled as given).
- late_err is sticky until err_clr. Set has priority over a same-cycle err_clr.
- Wrap-around: comparisons are modular. A trigger time just past the 2^TIME_WIDTH wrap is waited for, not treated as late, provided it lies within 2^(TIME_WIDTH−1) cycles ahead.

Test Plan:
- Reset, clear the timer, run=1, push (cmd=A, reg=0x12, time=20) at time 5:
  - pulse_write_en and cstrobe_out are high only in the cycle after time_cnt==20;
  - pulse_cmd_out=A and reg_out=0x12;
  - late_err stays 0.
- Push 8 entries with times 100..107 while run=0:
  - cmd_ready drops after the 8th push and a 9th cmd_valid is not accepted;
  - set run=1 from time 0: eight consecutive strobes occur in the cycles after time_cnt=100..107, in FIFO order.
- Push an entry with time 3 when time_cnt=50:
  - it issues within 2 cycles after becoming head;
  - late_err=1 and stays 1 until err_clr, then 0.
- Preload time_cnt near 2^32−4 (via timer run), push time=2:
  - no early issue;
  - strobe follows time_cnt==2 after the wrap;
  - late_err stays 0.
- Queue 3 entries, assert flush in the cycle the head matches:
  - no strobe;
  - fill_count=0 next cycle;
  - a same-cycle push is discarded.
- Drop rst_n asynchronously mid-stream with 4 entries queued:
  - outputs go to 0 immediately;
  - after release, fill_count=0 and no strobe occurs.

Source files
------------

// File: rtl/pulse_scheduler.sv
// Timed issue queue: buffers pulse commands with absolute trigger times and
// replays each one into the pulse register when the local timer reaches it.
module pulse_scheduler #(
  parameter int CMD_WIDTH  = 79,
  parameter int DATA_WIDTH = 32,
  parameter int TIME_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CMD_WIDTH-1:0]       cmd_in,
  input  logic [DATA_WIDTH-1:0]      reg_in,
  input  logic [TIME_WIDTH-1:0]      time_in,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       run,
  input  logic                       time_clr,
  input  logic                       flush,
  input  logic                       err_clr,
  output logic [CMD_WIDTH-1:0]       pulse_cmd_out,
  output logic [DATA_WIDTH-1:0]      reg_out,
  output logic                       pulse_write_en,
  output logic                       cstrobe_out,
  output logic [TIME_WIDTH-1:0]      time_cnt,
  output logic [$clog2(DEPTH):0]     fill_count,
  output logic                       late_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CMD_WIDTH-1:0]  cmd_mem_q  [DEPTH];
  logic [CMD_WIDTH-1:0]  cmd_mem_d  [DEPTH];
  logic [DATA_WIDTH-1:0] reg_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] reg_mem_d  [DEPTH];
  logic [TIME_WIDTH-1:0] time_mem_q [DEPTH];
  logic [TIME_WIDTH-1:0] time_mem_d [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [TIME_WIDTH-1:0] time_cnt_q, time_cnt_d;
  logic [CMD_WIDTH-1:0]  pulse_cmd_q, pulse_cmd_d;
  logic [DATA_WIDTH-1:0] reg_out_q, reg_out_d;
  logic                  strobe_q, strobe_d;
  logic                  late_err_q, late_err_d;

  logic [TIME_WIDTH-1:0] diff_s;
  logic                  not_empty_s;
  logic                  push_s;
  logic                  issue_s;
  logic                  late_s;

  assign cmd_ready = (count_q < CW'(DEPTH));

  // Issue decision: modular difference between head trigger time and timer
  always_comb begin
    diff_s      = time_mem_q[rd_ptr_q] - time_cnt_q;
    not_empty_s = (count_q != {CW{1'b0}});
    late_s      = diff_s[TIME_WIDTH-1];
    issue_s     = not_empty_s && run && !flush &&
                  ((diff_s == {TIME_WIDTH{1'b0}}) || late_s);
    push_s      = cmd_valid && cmd_ready && !flush;
  end

  // Next-state for queue storage, pointers, count, timer and outputs
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cmd_mem_d[i]  = cmd_mem_q[i];
      reg_mem_d[i]  = reg_mem_q[i];
      time_mem_d[i] = time_mem_q[i];
    end
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    time_cnt_d  = time_cnt_q;
    pulse_cmd_d = pulse_cmd_q;
    reg_out_d   = reg_out_q;
    strobe_d    = issue_s;
    late_err_d  = late_err_q;

    if (push_s) begin
      cmd_mem_d[wr_ptr_q]  = cmd_in;
      reg_mem_d[wr_ptr_q]  = reg_in;
      time_mem_d[wr_ptr_q] = time_in;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Flush wins over push/pop; issue_s is already masked by flush
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr_ptr_d = push_s  ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = issue_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      case ({push_s, issue_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (issue_s) begin
      pulse_cmd_d = cmd_mem_q[rd_ptr_q];
      reg_out_d   = reg_mem_q[rd_ptr_q];
    end else begin
      pulse_cmd_d = pulse_cmd_q;
      reg_out_d   = reg_out_q;
    end

    if (issue_s && late_s) begin
      late_err_d = 1'b1;
    end else if (err_clr) begin
      late_err_d = 1'b0;
    end else begin
      late_err_d = late_err_q;
    end

    if (time_clr) begin
      time_cnt_d = {TIME_WIDTH{1'b0}};
    end else if (run) begin
      time_cnt_d = time_cnt_q + TIME_WIDTH'(1);
    end else begin
      time_cnt_d = time_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cmd_mem_q[i]  <= {CMD_WIDTH{1'b0}};
        reg_mem_q[i]  <= {DATA_WIDTH{1'b0}};
        time_mem_q[i] <= {TIME_WIDTH{1'b0}};
      end
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      time_cnt_q  <= {TIME_WIDTH{1'b0}};
      pulse_cmd_q <= {CMD_WIDTH{1'b0}};
      reg_out_q   <= {DATA_WIDTH{1'b0}};
      strobe_q    <= 1'b0;
      late_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        cmd_mem_q[i]  <= cmd_mem_d[i];
        reg_mem_q[i]  <= reg_mem_d[i];
        time_mem_q[i] <= time_mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      time_cnt_q  <= time_cnt_d;
      pulse_cmd_q <= pulse_cmd_d;
      reg_out_q   <= reg_out_d;
      strobe_q    <= strobe_d;
      late_err_q  <= late_err_d;
    end
  end

  assign pulse_cmd_out  = pulse_cmd_q;
  assign reg_out        = reg_out_q;
  assign pulse_write_en = strobe_q;
  assign cstrobe_out    = strobe_q;
  assign time_cnt       = time_cnt_q;
  assign fill_count     = count_q;
  assign late_err       = late_err_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler; a 12-bit timer keeps the wrap case short.
module tb_pulse_scheduler;

  localparam int CMD_WIDTH  = 79;
  localparam int DATA_WIDTH = 32;
  localparam int TIME_WIDTH = 12;
  localparam int DEPTH      = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [CMD_WIDTH-1:0]  cmd_in = '0;
  logic [DATA_WIDTH-1:0] reg_in = '0;
  logic [TIME_WIDTH-1:0] time_in = '0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic                  run = 1'b0;
  logic                  time_clr = 1'b0;
  logic                  flush = 1'b0;
  logic                  err_clr = 1'b0;
  logic [CMD_WIDTH-1:0]  pulse_cmd_out;
  logic [DATA_WIDTH-1:0] reg_out;
  logic                  pulse_write_en;
  logic                  cstrobe_out;
  logic [TIME_WIDTH-1:0] time_cnt;
  logic [3:0]            fill_count;
  logic                  late_err;

  typedef struct {
    logic [CMD_WIDTH-1:0]  cmd;
    logic [DATA_WIDTH-1:0] rv;
    logic [TIME_WIDTH-1:0] t_strobe;
    logic                  late;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  pulse_scheduler #(
    .CMD_WIDTH(CMD_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .TIME_WIDTH(TIME_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .reg_in(reg_in),
    .time_in(time_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .run(run), .time_clr(time_clr), .flush(flush), .err_clr(err_clr),
    .pulse_cmd_out(pulse_cmd_out), .reg_out(reg_out),
    .pulse_write_en(pulse_write_en), .cstrobe_out(cstrobe_out),
    .time_cnt(time_cnt), .fill_count(fill_count), .late_err(late_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_time(input logic [TIME_WIDTH-1:0] t, input int bound);
    int n;
    n = 0;
    while (time_cnt !== t && n < bound) begin
      tick();
      n++;
    end
    check("wait_time_reached", 128'(time_cnt), 128'(t));
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_scoreboard", 128'(sb.size()), 128'd0);
  endtask

  function automatic logic [CMD_WIDTH-1:0] mk_cmd(input int i);
    return {15'(i + 16'h0100), 64'hC0DE_0000_0000_0000 + 64'(i)};
  endfunction

  // Monitor: every strobe must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && (pulse_write_en || cstrobe_out)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 128'(time_cnt), 128'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_we", 128'(pulse_write_en), 128'd1);
        check("strobe_cs", 128'(cstrobe_out), 128'd1);
        check("strobe_cmd", 128'(pulse_cmd_out), 128'(e.cmd));
        check("strobe_reg", 128'(reg_out), 128'(e.rv));
        check("strobe_time", 128'(time_cnt), 128'(e.t_strobe));
        check("strobe_late", 128'(late_err), 128'(e.late));
      end
    end
  end

  initial begin
    exp_t e;
    // Reset state
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_we", 128'(pulse_write_en), 128'd0);
    check("rst_time", 128'(time_cnt), 128'd0);
    check("rst_fill", 128'(fill_count), 128'd0);
    check("rst_late", 128'(late_err), 128'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 128'(cmd_ready), 128'd1);

    // Single on-time issue
    time_clr = 1'b1; run = 1'b1; tick(); time_clr = 1'b0;
    wait_time(12'd5, 20);
    cmd_in = {15'h0A0A, 64'hA5A5_0000_DEAD_BEEF}; reg_in = 32'h12; time_in = 12'd20;
    cmd_valid = 1'b1;
    e.cmd = cmd_in; e.rv = 32'h12; e.t_strobe = 12'd21; e.late = 1'b0;
    sb.push_back(e);
    tick(); cmd_valid = 1'b0;
    wait_drain(40);
    check("t1_late", 128'(late_err), 128'd0);

    // Fill queue while stopped, then drain in FIFO order
    run = 1'b0; time_clr = 1'b1; tick(); time_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cmd_in = mk_cmd(i); reg_in = 32'h5000 + 32'(i); time_in = 12'(100 + i);
      cmd_valid = 1'b1;
      e.cmd = cmd_in; e.rv = reg_in; e.t_strobe = 12'(101 + i); e.late = 1'b0;
      sb.push_back(e);
      tick();
    end
    check("full_ready", 128'(cmd_ready), 128'd0);
    check("full_fill", 128'(fill_count), 128'd8);
    cmd_in = mk_cmd(99); time_in = 12'd50; cmd_valid = 1'b1;
    tick(); cmd_valid = 1'b0;
    check("ninth_rejected", 128'(fill_count), 128'd8);
    check("stopped_time", 128'(time_cnt), 128'd0);
    run = 1'b1;
    wait_drain(200);

    // Late entry and sticky error
    time_clr = 1'b1; tick(); time_clr = 1'b0;
    wait_time(12'd50, 80);
    cmd_in = mk_cmd(33); reg_in = 32'h3333; time_in = 12'd3; cmd_valid = 1'b1;
    e.cmd = cmd_in; e.rv = reg_in; e.t_strobe = 12'd52; e.late = 1'b1;
    sb.push_back(e);
    tick(); cmd_valid = 1'b0;
    wait_drain(10);
    tick(); tick(); tick();
    check("late_sticky", 128'(late_err), 128'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("late_cleared", 128'(late_err), 128'd0);

    // Timer wrap: trigger just past the wrap must wait
    time_clr = 1'b1; tick(); time_clr = 1'b0;
    wait_time(12'd4092, 5000);
    cmd_in = mk_cmd(44); reg_in = 32'h4444; time_in = 12'd2; cmd_valid = 1'b1;
    e.cmd = cmd_in; e.rv = reg_in; e.t_strobe = 12'd3; e.late = 1'b0;
    sb.push_back(e);
    tick(); cmd_valid = 1'b0;
    tick();
    check("wrap_waiting", 128'(fill_count), 128'd1);
    wait_drain(20);
    check("wrap_late", 128'(late_err), 128'd0);

    // Flush on the head-match cycle with a same-cycle push
    time_clr = 1'b1; tick(); time_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_in = mk_cmd(60 + i); reg_in = 32'h6000 + 32'(i); time_in = 12'(30 + i);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    wait_time(12'd30, 40);
    check("flush_pre_fill", 128'(fill_count), 128'd3);
    flush = 1'b1; cmd_valid = 1'b1; cmd_in = mk_cmd(70); time_in = 12'd40;
    tick(); flush = 1'b0; cmd_valid = 1'b0;
    check("flush_fill", 128'(fill_count), 128'd0);
    check("flush_ready", 128'(cmd_ready), 128'd1);
    repeat (30) tick();
    check("flush_no_entry", 128'(fill_count), 128'd0);

    // Asynchronous reset with entries queued
    time_clr = 1'b1; tick(); time_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_in = mk_cmd(80 + i); reg_in = 32'h8000 + 32'(i); time_in = 12'(200 + i);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    check("pre_rst_fill", 128'(fill_count), 128'd4);
    #3 rst_n = 1'b0;
    #1;
    check("arst_cmd", 128'(pulse_cmd_out), 128'd0);
    check("arst_reg", 128'(reg_out), 128'd0);
    check("arst_we", 128'(pulse_write_en), 128'd0);
    check("arst_time", 128'(time_cnt), 128'd0);
    check("arst_fill", 128'(fill_count), 128'd0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_fill", 128'(fill_count), 128'd0);
    repeat (250) tick();
    check("post_rst_no_entry", 128'(fill_count), 128'd0);
    check("final_sb_empty", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
